// File: rtl/fft_helpers_twiddle_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_helpers_twiddle_sequencer_if                                     |
// | Start handshake and twiddle-pair stream between control and datapath |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface fft_helpers_twiddle_sequencer_if #(
  parameter int N = 8,
  parameter int W = 32
);
  localparam int c_lg = $clog2(N);

  logic            start_val;
  logic            start_rdy;
  logic            out_val;
  logic            out_rdy;
  logic [W-1:0]    out_re;
  logic [W-1:0]    out_im;
  logic [c_lg-1:0] out_stage;
  logic [c_lg-1:0] out_k;
  logic            out_last;

  modport master (
    input  start_val,
    output start_rdy,
    output out_val,
    input  out_rdy,
    output out_re,
    output out_im,
    output out_stage,
    output out_k,
    output out_last
  );

  modport slave (
    output start_val,
    input  start_rdy,
    input  out_val,
    output out_rdy,
    input  out_re,
    input  out_im,
    input  out_stage,
    input  out_k,
    input  out_last
  );
endinterface
`default_nettype wire

// File: rtl/fft_helpers_twiddle_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fft_helpers_twiddle_sequencer                                        |
// | Streams radix-2 DIT twiddle pairs stage by stage from a sine table.  |
// | Option macro: FFT_HELPERS_TWIDDLE_INVERSE_EN adds the inverse input. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fft_helpers_twiddle_sequencer #(
  parameter int N = 8,
  parameter int W = 32,
  parameter int D = 16
) (
  input  logic clk,
  input  logic reset_n,
`ifdef FFT_HELPERS_TWIDDLE_INVERSE_EN
  input  logic inverse,
`endif
  fft_helpers_twiddle_sequencer_if.master bus
);
  localparam int              c_lg      = $clog2(N);
  localparam real             c_pi      = 3.14159265358979323846;
  localparam logic [c_lg-1:0] c_top     = c_lg'(c_lg - 1);
  localparam logic [c_lg-1:0] c_quarter = c_lg'(N / 4);
  localparam logic [c_lg-1:0] c_half    = c_lg'(N / 2);
  localparam logic [c_lg-1:0] c_k_last  = c_lg'(N / 2 - 1);

  // Elaboration-time sine; the argument is folded into [-pi, pi] first.
  function automatic real sin_taylor(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int n = 1; n < 20; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  // Sign is taken from bit 31 of the rounded integer, so +1.0 stays positive.
  function automatic logic [W-1:0] tab_entry(input int i);
    real                ang;
    int                 v;
    logic signed [D+1:0] t;
    ang = 2.0 * c_pi * real'(i) / real'(N);
    if (ang > c_pi) ang = ang - 2.0 * c_pi;
    v = int'(sin_taylor(ang) * (2.0 ** D));
    t = {v[31], v[D:0]};
    return W'(t);
  endfunction

  logic [W-1:0] w_tab [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_tab
    localparam logic [W-1:0] c_val = tab_entry(gi);
    assign w_tab[gi] = c_val;
  end

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_lg-1:0] r_s;
  logic [c_lg-1:0] r_k;
  logic [c_lg-1:0] w_s_nxt;
  logic [c_lg-1:0] w_k_nxt;
  logic [c_lg-1:0] w_shamt;
  logic [c_lg-1:0] w_j;
  logic [c_lg-1:0] w_re_idx;
  logic [c_lg-1:0] w_im_idx;
  logic [c_lg:0]   w_kp1;
  logic [c_lg:0]   w_span;
  logic            w_stage_end;
  logic            w_last;
  logic            r_inv;

  // j = k * (N >> (s+1)) is a left shift by (log2(N)-1-s).
  assign w_shamt     = c_top - r_s;
  assign w_j         = r_k << w_shamt;
  assign w_re_idx    = w_j + c_quarter;
  assign w_im_idx    = r_inv ? w_j : (w_j + c_half);
  assign w_kp1       = {1'b0, r_k} + (c_lg+1)'(1);
  assign w_span      = (c_lg+1)'(1) << r_s;
  assign w_stage_end = (w_kp1 == w_span);
  assign w_last      = (r_s == c_top) && (r_k == c_k_last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_s     <= '0;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_s     <= w_s_nxt;
      r_k     <= w_k_nxt;
    end
  end

`ifdef FFT_HELPERS_TWIDDLE_INVERSE_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inv <= 1'b0;
    end else if (r_state == S_IDLE && bus.start_val) begin
      r_inv <= inverse;
    end
  end
`else
  assign r_inv = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_s_nxt       = r_s;
    w_k_nxt       = r_k;
    bus.start_rdy = 1'b0;
    bus.out_val   = 1'b0;
    bus.out_re    = '0;
    bus.out_im    = '0;
    bus.out_stage = '0;
    bus.out_k     = '0;
    bus.out_last  = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.start_rdy = 1'b1;
        if (bus.start_val) begin
          w_state_nxt = S_RUN;
          w_s_nxt     = '0;
          w_k_nxt     = '0;
        end
      end
      S_RUN: begin
        bus.out_val   = 1'b1;
        bus.out_re    = w_tab[w_re_idx];
        bus.out_im    = w_tab[w_im_idx];
        bus.out_stage = r_s;
        bus.out_k     = r_k;
        bus.out_last  = w_last;
        if (bus.out_rdy) begin
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_s_nxt     = '0;
            w_k_nxt     = '0;
          end else if (w_stage_end) begin
            w_k_nxt = '0;
            w_s_nxt = r_s + c_lg'(1);
          end else begin
            w_k_nxt = r_k + c_lg'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
endmodule
`default_nettype wire

// File: tb/tb_fft_helpers_twiddle_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fft_helpers_twiddle_sequencer                                     |
// | Scoreboard bench for the twiddle sequencer (N=8, W=32, D=16).        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fft_helpers_twiddle_sequencer;
  localparam int N  = 8;
  localparam int W  = 32;
  localparam int D  = 16;
  localparam int LG = 3;

  typedef struct packed {
    logic [W-1:0]  re;
    logic [W-1:0]  im;
    logic [LG-1:0] st;
    logic [LG-1:0] k;
    logic          last;
  } pair_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fft_helpers_twiddle_sequencer_if #(.N(N), .W(W)) bus ();
`ifdef FFT_HELPERS_TWIDDLE_INVERSE_EN
  logic inverse = 1'b0;
`endif

  fft_helpers_twiddle_sequencer #(.N(N), .W(W), .D(D)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef FFT_HELPERS_TWIDDLE_INVERSE_EN
    .inverse (inverse),
`endif
    .bus     (bus)
  );

  // Hand-computed sweep for N=8: j = 0,0,2,0,1,2,3.
  logic [W-1:0] fwd_re [7] = '{32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0001_0000,
                                32'h0000_B505, 32'h0000_0000, 32'hFFFF_4AFB};
  logic [W-1:0] fwd_im [7] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_0000, 32'h0000_0000,
                                32'hFFFF_4AFB, 32'hFFFF_0000, 32'hFFFF_4AFB};
  logic [W-1:0] inv_im [7] = '{32'h0000_0000, 32'h0000_0000, 32'h0001_0000, 32'h0000_0000,
                                32'h0000_B505, 32'h0001_0000, 32'h0000_B505};
  int exp_st [7] = '{0, 1, 1, 2, 2, 2, 2};
  int exp_k  [7] = '{0, 0, 1, 0, 1, 2, 3};

  pair_t q[$];
  int    errors = 0;
  int    checks = 0;
  int    acc = 0;
  int    cyc = 0;
  int    acc_cyc [128];
  int    base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_sweep(input bit inv);
    pair_t p;
    for (int i = 0; i < 7; i++) begin
      p.re   = fwd_re[i];
      p.im   = inv ? inv_im[i] : fwd_im[i];
      p.st   = LG'(exp_st[i]);
      p.k    = LG'(exp_k[i]);
      p.last = (i == 6);
      q.push_back(p);
    end
  endtask

  // Monitor: pops on every accepted pair, checks hold-stability while stalled.
  always @(negedge clk) begin : mon
    pair_t a;
    if (reset_n && bus.out_val) begin
      a.re   = bus.out_re;
      a.im   = bus.out_im;
      a.st   = bus.out_stage;
      a.k    = bus.out_k;
      a.last = bus.out_last;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pair: got %h expected none", a);
      end else if (bus.out_rdy) begin
        check($sformatf("pair%0d", acc), a, q.pop_front());
        acc_cyc[acc] = cyc;
        acc++;
      end else begin
        check($sformatf("stall_hold%0d", acc), a, q[0]);
      end
    end
  end

  task automatic wait_acc(input int t);
    int n = 0;
    while (acc < t && n < 100) begin
      @(posedge clk);
      n++;
    end
    check($sformatf("reach_acc%0d", t), (acc >= t), 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", q.size(), 0);
  endtask

  task automatic start_sweep(input bit inv);
    @(posedge clk); #1;
    check("start_rdy_idle", bus.start_rdy, 1);
    bus.start_val = 1'b1;
`ifdef FFT_HELPERS_TWIDDLE_INVERSE_EN
    inverse = inv;
`endif
    push_sweep(inv);
    @(posedge clk); #1;
    bus.start_val = 1'b0;
`ifdef FFT_HELPERS_TWIDDLE_INVERSE_EN
    inverse = ~inv;
`endif
    check("latency_out_val", bus.out_val, 1);
    check("start_rdy_busy", bus.start_rdy, 0);
  endtask

  initial begin
    bus.start_val = 1'b0;
    bus.out_rdy   = 1'b1;
    #12;
    check("rst_start_rdy", bus.start_rdy, 1);
    check("rst_out_val", bus.out_val, 0);
    check("rst_out_re", bus.out_re, 0);
    check("rst_out_im", bus.out_im, 0);
    check("rst_out_stage", bus.out_stage, 0);
    check("rst_out_k", bus.out_k, 0);
    check("rst_out_last", bus.out_last, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Plain forward sweep
    base = acc;
    start_sweep(1'b0);
    wait_acc(base + 7);
    #1;
    check("idle_after_last_rdy", bus.start_rdy, 1);
    check("idle_after_last_val", bus.out_val, 0);
    wait_drain();

    // Stall three cycles on pair 5
    base = acc;
    start_sweep(1'b0);
    wait_acc(base + 4);
    #1 bus.out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.out_rdy = 1'b1;
    wait_acc(base + 7);
    wait_drain();
    check("stall_count", acc - base, 7);

    // start_val mid-sweep is ignored
    base = acc;
    start_sweep(1'b0);
    wait_acc(base + 2);
    #1 bus.start_val = 1'b1;
    @(posedge clk); #1;
    check("start_ignored_rdy", bus.start_rdy, 0);
    bus.start_val = 1'b0;
    wait_acc(base + 7);
    wait_drain();
    repeat (2) @(posedge clk);
    #1 check("no_extra_sweep", bus.out_val, 0);

    // Asynchronous reset while pair 3 is presented
    base = acc;
    start_sweep(1'b0);
    wait_acc(base + 2);
    #2;
    check("pre_reset_stage", bus.out_stage, 1);
    check("pre_reset_k", bus.out_k, 1);
    reset_n = 1'b0;
    #1;
    check("async_rst_out_val", bus.out_val, 0);
    check("async_rst_start_rdy", bus.start_rdy, 1);
    check("async_rst_out_im", bus.out_im, 0);
    q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    base = acc;
    start_sweep(1'b0);
    wait_acc(base + 7);
    wait_drain();

    // Back-to-back sweeps with start_val held high
    @(posedge clk); #1;
    base = acc;
    bus.start_val = 1'b1;
    push_sweep(1'b0);
    push_sweep(1'b0);
    wait_acc(base + 7);
    @(posedge clk); #1;
    bus.start_val = 1'b0;
    wait_acc(base + 14);
    wait_drain();
    check("b2b_gap", acc_cyc[base + 7] - acc_cyc[base + 6], 2);
    check("b2b_total", acc - base, 14);

`ifdef FFT_HELPERS_TWIDDLE_INVERSE_EN
    base = acc;
    start_sweep(1'b1);
    wait_acc(base + 7);
    wait_drain();
    base = acc;
    start_sweep(1'b0);
    wait_acc(base + 7);
    wait_drain();
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
